multimode_solver_control: RTL and testbench

//  Sequencer for the multi-limb escape-time datapath; successor to the single-mode solver controller.

---
 rtl/multimode_solver_control_if.sv | 39 +++
 rtl/multimode_solver_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multimode_solver_control.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multimode_solver_control_if.sv
// Host-side bus of the multimode solver controller: configuration writes,
// c-limb writes, start/abort and the result handshake.
//
// Result handshake: out_valid rises when a result is held and stays high,
// with out_count/out_escaped stable, until a cycle where out_ready is also
// high. That cycle is the transfer, and out_valid falls on the next cycle.
// The only other way out_valid falls is abort, which transfers nothing.
interface multimode_solver_control_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int ITER_BITS       = 16
);
  logic                       cfg_wr_en;
  logic [LIMB_INDEX_BITS-1:0] cfg_limbs;
  logic [ITER_BITS-1:0]       cfg_limit;
  logic [1:0]                 cfg_mode;
  logic                       c_wr_re;
  logic                       c_wr_im;
  logic [LIMB_INDEX_BITS-1:0] c_wr_ind;
  logic                       start;
  logic                       abort;
  logic                       out_valid;
  logic                       out_ready;
  logic [ITER_BITS-1:0]       out_count;
  logic                       out_escaped;

  // Host side
  modport master (
    output cfg_wr_en, cfg_limbs, cfg_limit, cfg_mode,
    output c_wr_re, c_wr_im, c_wr_ind, start, abort, out_ready,
    input  out_valid, out_count, out_escaped
  );

  // Controller side
  modport slave (
    input  cfg_wr_en, cfg_limbs, cfg_limit, cfg_mode,
    input  c_wr_re, c_wr_im, c_wr_ind, start, abort, out_ready,
    output out_valid, out_count, out_escaped
  );
endinterface

// File: rtl/multimode_solver_control.sv
// Sequencer for the multi-limb escape-time datapath. Each z iteration runs an
// optional abs pass over the limbs (Burning Ship), a pipeline flush, the
// triangular partial-product schedule column by column from the least
// significant column (k=N-1) down to 0, a second flush and a divergence check.
// Limb 0 is the most significant limb.
module multimode_solver_control #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int ITER_BITS       = 16,
  parameter int PIPE_DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  multimode_solver_control_if.slave  host,
  input  logic                       zre_sign,
  input  logic                       zim_sign,
  input  logic                       diverged,
  output logic                       c_wr_re_o,
  output logic                       c_wr_im_o,
  output logic [LIMB_INDEX_BITS-1:0] c_ind,
  output logic [LIMB_INDEX_BITS-1:0] rd_a_ind,
  output logic [LIMB_INDEX_BITS-1:0] rd_b_ind,
  output logic                       abs_re,
  output logic                       abs_im,
  output logic                       abs_first,
  output logic                       pp_valid,
  output logic                       pp_double,
  output logic                       pp_suppress,
  output logic                       im_conj,
  output logic                       col_first,
  output logic                       col_last,
  output logic                       z_wr_en,
  output logic [LIMB_INDEX_BITS-1:0] z_wr_ind,
  output logic                       busy,
  output logic [2:0]                 state_dbg
);

  localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ABS        = 3'd1,
    S_ABS_FLUSH  = 3'd2,
    S_ITER       = 3'd3,
    S_ITER_FLUSH = 3'd4,
    S_CHECK      = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LIMB_INDEX_BITS-1:0] num_limbs;
  logic [ITER_BITS-1:0]       iter_limit;
  logic [1:0]                 mode;
  logic [ITER_BITS-1:0]       count;
  logic                       zre_lat;
  logic                       zim_lat;
  logic                       escaped;
  logic [LIMB_INDEX_BITS-1:0] abs_idx;
  logic [LIMB_INDEX_BITS-1:0] col_k;
  logic [LIMB_INDEX_BITS-1:0] pair_i;
  logic [FW-1:0]              fcnt;

  logic [LIMB_INDEX_BITS-1:0] col_half;
  logic [LIMB_INDEX_BITS-1:0] pair_j;
  logic                       pair_last;
  logic                       flush_done;
  logic                       start_ok;
  logic                       div_hit;
  logic                       limit_hit;
  logic                       mode_bs;
  logic                       mode_tc;

  // Shared decode of the schedule and check conditions
  always_comb begin
    col_half   = col_k >> 1;
    pair_j     = col_k - pair_i;
    pair_last  = (pair_i == col_half);
    flush_done = (fcnt == FLUSH_LAST);
    start_ok   = host.start && !host.abort && (num_limbs != '0);
    div_hit    = diverged && (count != '0);
    limit_hit  = (count == iter_limit);
    mode_bs    = (mode == 2'd1);
    mode_tc    = (mode == 2'd2);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start_ok) state_nxt = mode_bs ? S_ABS : S_ITER;
      S_ABS:        if (abs_idx == '0) state_nxt = S_ABS_FLUSH;
      S_ABS_FLUSH:  if (flush_done) state_nxt = S_ITER;
      S_ITER:       if (pair_last && (col_k == '0)) state_nxt = S_ITER_FLUSH;
      S_ITER_FLUSH: if (flush_done) state_nxt = S_CHECK;
      S_CHECK: begin
        if (div_hit || limit_hit) state_nxt = S_DONE;
        else                      state_nxt = mode_bs ? S_ABS : S_ITER;
      end
      S_DONE:       if (host.out_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (host.abort) state_nxt = S_IDLE;
  end

  // Configuration, iteration counter, schedule indices and flush timer
  always_ff @(posedge clock) begin
    if (reset) begin
      num_limbs  <= LIMB_INDEX_BITS'(1);
      iter_limit <= '0;
      mode       <= 2'd0;
      count      <= '0;
      zre_lat    <= 1'b0;
      zim_lat    <= 1'b0;
      escaped    <= 1'b0;
      abs_idx    <= '0;
      col_k      <= '0;
      pair_i     <= '0;
      fcnt       <= '0;
    end else begin
      fcnt <= '0;
      case (state)
        S_IDLE: begin
          if (host.cfg_wr_en) begin
            num_limbs  <= host.cfg_limbs;
            iter_limit <= host.cfg_limit;
            // Mode 3 is reserved and behaves as Mandelbrot
            mode       <= (host.cfg_mode == 2'd3) ? 2'd0 : host.cfg_mode;
          end
          if (start_ok) begin
            count   <= '0;
            zre_lat <= 1'b0;
            zim_lat <= 1'b0;
            escaped <= 1'b0;
            abs_idx <= num_limbs - 1'b1;
            col_k   <= num_limbs - 1'b1;
            pair_i  <= '0;
          end
        end
        S_ABS: begin
          if (abs_idx != '0) abs_idx <= abs_idx - 1'b1;
        end
        S_ABS_FLUSH, S_ITER_FLUSH: begin
          fcnt <= fcnt + 1'b1;
        end
        S_ITER: begin
          if (pair_last) begin
            pair_i <= '0;
            if (col_k != '0) col_k <= col_k - 1'b1;
          end else begin
            pair_i <= pair_i + 1'b1;
          end
        end
        S_CHECK: begin
          if (div_hit) begin
            escaped <= 1'b1;
          end else if (limit_hit) begin
            escaped <= 1'b0;
          end else begin
            count   <= count + 1'b1;
            abs_idx <= num_limbs - 1'b1;
            col_k   <= num_limbs - 1'b1;
            pair_i  <= '0;
            if (mode_bs) begin
              zre_lat <= zre_sign;
              zim_lat <= zim_sign;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and host outputs decoded from the current state
  always_comb begin
    c_wr_re_o        = 1'b0;
    c_wr_im_o        = 1'b0;
    c_ind            = '0;
    rd_a_ind         = '0;
    rd_b_ind         = '0;
    abs_re           = 1'b0;
    abs_im           = 1'b0;
    abs_first        = 1'b0;
    pp_valid         = 1'b0;
    pp_double        = 1'b0;
    pp_suppress      = 1'b0;
    im_conj          = 1'b0;
    col_first        = 1'b0;
    col_last         = 1'b0;
    z_wr_en          = 1'b0;
    z_wr_ind         = '0;
    busy             = (state != S_IDLE);
    host.out_valid   = 1'b0;
    host.out_count   = '0;
    host.out_escaped = 1'b0;
    state_dbg        = state;
    case (state)
      S_IDLE: begin
        c_wr_re_o = host.c_wr_re;
        c_wr_im_o = host.c_wr_im;
        c_ind     = host.c_wr_ind;
      end
      S_ABS: begin
        rd_a_ind  = abs_idx;
        rd_b_ind  = abs_idx;
        c_ind     = abs_idx;
        abs_re    = zre_lat;
        abs_im    = zim_lat;
        abs_first = (abs_idx == num_limbs - 1'b1);
      end
      S_ITER: begin
        rd_a_ind    = pair_i;
        rd_b_ind    = pair_j;
        c_ind       = pair_i;
        pp_valid    = 1'b1;
        pp_double   = (pair_i != pair_j);
        // Iteration 0 produces z1 = c, so the squared terms are zeroed
        pp_suppress = (count == '0);
        im_conj     = mode_tc;
        col_first   = (pair_i == '0);
        col_last    = pair_last;
        z_wr_en     = pair_last;
        z_wr_ind    = col_k;
      end
      S_DONE: begin
        host.out_valid   = 1'b1;
        host.out_count   = count;
        host.out_escaped = escaped;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multimode_solver_control.sv
// Directed bench for multimode_solver_control: schedule order, abs pass,
// mode terms, result handshake, abort, config locking and mid-run reset.
module tb_multimode_solver_control;
  localparam int LB = 6;
  localparam int IB = 16;
  localparam int PD = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ABS = 3'd1;
  localparam logic [2:0] ST_ABS_FLUSH = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multimode_solver_control_if #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB)) host_if ();

  logic          zre_sign, zim_sign, diverged;
  logic          c_wr_re_o, c_wr_im_o;
  logic [LB-1:0] c_ind, rd_a_ind, rd_b_ind, z_wr_ind;
  logic          abs_re, abs_im, abs_first, pp_valid, pp_double, pp_suppress, im_conj;
  logic          col_first, col_last, z_wr_en, busy;
  logic [2:0]    state_dbg;

  multimode_solver_control #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .PIPE_DEPTH(PD)) dut (
    .clock(clock), .reset(reset), .host(host_if),
    .zre_sign(zre_sign), .zim_sign(zim_sign), .diverged(diverged),
    .c_wr_re_o(c_wr_re_o), .c_wr_im_o(c_wr_im_o), .c_ind(c_ind),
    .rd_a_ind(rd_a_ind), .rd_b_ind(rd_b_ind),
    .abs_re(abs_re), .abs_im(abs_im), .abs_first(abs_first),
    .pp_valid(pp_valid), .pp_double(pp_double), .pp_suppress(pp_suppress),
    .im_conj(im_conj), .col_first(col_first), .col_last(col_last),
    .z_wr_en(z_wr_en), .z_wr_ind(z_wr_ind), .busy(busy), .state_dbg(state_dbg)
  );

  // scoreboard: expected {escaped, count} per solve
  logic [IB:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // N=4 schedule: (rd_a, rd_b, col_first, col_last, pp_double, column)
  int exp_a[6]   = '{0, 1, 0, 1, 0, 0};
  int exp_b[6]   = '{3, 2, 2, 1, 1, 0};
  int exp_cf[6]  = '{1, 0, 1, 0, 1, 1};
  int exp_cl[6]  = '{0, 1, 0, 1, 1, 1};
  int exp_dbl[6] = '{1, 1, 1, 0, 1, 0};
  int exp_k[6]   = '{3, 3, 2, 2, 1, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic configure(input int n, input int l, input int m);
    host_if.cfg_limbs = LB'(n);
    host_if.cfg_limit = IB'(l);
    host_if.cfg_mode  = 2'(m);
    host_if.cfg_wr_en = 1'b1;
    step();
    host_if.cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    host_if.start = 1'b1;
    step();
    host_if.start = 1'b0;
  endtask

  task automatic wait_pp(output bit ok);
    int n = 0;
    while (!pp_valid && n < 300) begin
      step();
      n++;
    end
    ok = pp_valid;
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    int n = 0;
    while (state_dbg != s && n < 300) begin
      step();
      n++;
    end
    ok = (state_dbg == s);
  endtask

  task automatic check_iter4(input string tag);
    bit ok;
    wait_pp(ok);
    if (!ok) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      for (int j = 0; j < 6; j++) begin
        check($sformatf("%s_pair%0d", tag, j),
              {pp_valid, rd_a_ind, rd_b_ind, col_first, col_last, z_wr_en, pp_double, z_wr_ind},
              {1'b1, LB'(exp_a[j]), LB'(exp_b[j]), exp_cf[j] != 0, exp_cl[j] != 0,
               exp_cl[j] != 0, exp_dbl[j] != 0, LB'(exp_k[j])});
        step();
      end
      check({tag, "_end"}, pp_valid, 0);
    end
  endtask

  task automatic check_result(input string tag);
    bit ok;
    logic [IB:0] e;
    int n = 0;
    while (!host_if.out_valid && n < 3000) begin
      step();
      n++;
    end
    e = exp_q.pop_front();
    if (!host_if.out_valid) check({tag, "_timeout"}, 0, 1);
    else check(tag, {host_if.out_escaped, host_if.out_count}, e);
    ok = 1'b1;
  endtask

  task automatic measure_flush(input string tag);
    int n = 0;
    while (state_dbg == ST_ABS_FLUSH && n < 20) begin
      step();
      n++;
    end
    check(tag, n, PD);
  endtask

  initial begin
    bit ok;
    bit seen;
    reset = 1'b1;
    host_if.cfg_wr_en = 0; host_if.cfg_limbs = 0; host_if.cfg_limit = 0; host_if.cfg_mode = 0;
    host_if.c_wr_re = 0; host_if.c_wr_im = 0; host_if.c_wr_ind = 0;
    host_if.start = 0; host_if.abort = 0; host_if.out_ready = 1;
    zre_sign = 0; zim_sign = 0; diverged = 0;
    repeat (3) step();
    reset = 1'b0;

    // reset state: every output 0
    check("reset_outs",
          {c_wr_re_o, c_wr_im_o, c_ind, rd_a_ind, rd_b_ind, abs_re, abs_im, abs_first,
           pp_valid, pp_double, pp_suppress, im_conj, col_first, col_last, z_wr_en, z_wr_ind},
          0);
    check("reset_res", {busy, host_if.out_valid, host_if.out_count, host_if.out_escaped, state_dbg}, 0);

    // c-write passthrough in IDLE
    host_if.c_wr_re = 1; host_if.c_wr_ind = 6'd5;
    #1;
    check("c_pass", {c_wr_re_o, c_wr_im_o, c_ind}, {1'b1, 1'b0, 6'd5});
    host_if.c_wr_re = 0; host_if.c_wr_ind = 0;

    // start with N==0 is ignored
    configure(0, 2, 0);
    pulse_start();
    check("n0_ignored", busy, 0);

    // A: N=4, Mandelbrot, L=3, never diverges
    configure(4, 3, 0);
    exp_q.push_back({1'b0, 16'd3});
    pulse_start();
    for (int it = 0; it < 4; it++) check_iter4($sformatf("A_it%0d", it));
    check_result("A_result");
    step();
    check("A_idle", {busy, host_if.out_valid}, 0);

    // B: N=2, Burning Ship, L=1; sign input high but not yet latched in iteration 0
    configure(2, 1, 1);
    zre_sign = 1; zim_sign = 0;
    exp_q.push_back({1'b0, 16'd1});
    pulse_start();
    check("B_abs0_l1", {state_dbg, abs_re, abs_im, abs_first, rd_a_ind}, {ST_ABS, 3'b001, 6'd1});
    step();
    check("B_abs0_l0", {state_dbg, abs_re, abs_im, abs_first, rd_a_ind}, {ST_ABS, 3'b000, 6'd0});
    step();
    measure_flush("B_flush0");
    wait_state(ST_CHECK, ok);
    check("B_check_reached", ok, 1);
    step();
    check("B_abs1_l1", {state_dbg, abs_re, abs_im, abs_first, rd_a_ind}, {ST_ABS, 3'b101, 6'd1});
    step();
    check("B_abs1_l0", {state_dbg, abs_re, abs_im, abs_first, rd_a_ind}, {ST_ABS, 3'b100, 6'd0});
    step();
    measure_flush("B_flush1");
    zre_sign = 0;
    check_result("B_result");
    step();

    // C: N=2, Tricorn, L=1, diverged held high; count 0 divergence ignored
    configure(2, 1, 2);
    diverged = 1;
    exp_q.push_back({1'b1, 16'd1});
    pulse_start();
    for (int j = 0; j < 2; j++) begin
      check($sformatf("C_it0_%0d", j), {pp_valid, im_conj, pp_suppress}, 3'b111);
      step();
    end
    wait_pp(ok);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("C_it1_%0d", j), {pp_valid, im_conj, pp_suppress}, 3'b110);
      step();
    end
    check_result("C_result");
    diverged = 0;
    step();

    // D: N=1, L=10, diverges at count 5, consumer stalls 10 cycles, start ignored
    configure(1, 10, 0);
    host_if.out_ready = 0;
    exp_q.push_back({1'b1, 16'd5});
    pulse_start();
    check("D_n1_iter", {pp_valid, col_first, col_last, z_wr_en, rd_a_ind, rd_b_ind}, {4'b1111, 12'd0});
    for (int j = 0; j <= 5; j++) begin
      wait_state(ST_CHECK, ok);
      diverged = (j == 5);
      step();
      diverged = 0;
    end
    check_result("D_result");
    for (int j = 0; j < 10; j++) begin
      host_if.start = (j == 3);
      check($sformatf("D_hold%0d", j),
            {state_dbg, host_if.out_valid, host_if.out_escaped, host_if.out_count},
            {ST_DONE, 1'b1, 1'b1, 16'd5});
      step();
    end
    host_if.start = 0;
    host_if.out_ready = 1;
    step();
    check("D_release", {busy, host_if.out_valid}, 0);

    // E: abort mid-ITER, then abort together with start
    configure(4, 3, 0);
    pulse_start();
    wait_pp(ok);
    step();
    host_if.abort = 1;
    step();
    host_if.abort = 0;
    check("E_abort", {busy, pp_valid, state_dbg}, {2'b00, ST_IDLE});
    seen = 0;
    for (int j = 0; j < 60; j++) begin
      seen |= host_if.out_valid;
      step();
    end
    check("E_no_result", seen, 0);
    host_if.abort = 1; host_if.start = 1;
    step();
    host_if.abort = 0; host_if.start = 0;
    check("E_abort_start", busy, 0);

    // F: config write while busy is ignored
    exp_q.push_back({1'b0, 16'd3});
    pulse_start();
    wait_pp(ok);
    step();
    configure(1, 0, 2);
    check("F_conj_unchanged", im_conj, 0);
    check_result("F_result");
    step();

    // G: reset mid-ITER, then next solve uses N=1, L=0
    pulse_start();
    wait_pp(ok);
    step();
    reset = 1;
    step();
    reset = 0;
    check("G_reset_outs",
          {c_wr_re_o, c_wr_im_o, c_ind, rd_a_ind, rd_b_ind, abs_re, abs_im, abs_first,
           pp_valid, pp_double, pp_suppress, im_conj, col_first, col_last, z_wr_en, z_wr_ind,
           busy, host_if.out_valid},
          0);
    exp_q.push_back({1'b0, 16'd0});
    pulse_start();
    check("G_n1", {pp_valid, col_first, col_last, rd_a_ind}, {3'b111, 6'd0});
    step();
    check("G_n1_one_cycle", pp_valid, 0);
    check_result("G_result");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
